// File: rtl/sal_bank_pkg.sv
// Shared types and default widths for the per-bank DDR2 sequencer.
package sal_bank_pkg;

   localparam int DEF_TW     = 8;
   localparam int DEF_ROW_AW = 14;

   typedef enum logic [2:0] {
      IDLE,
      ACTIVATING,
      ACTIVE,
      PRECHARGING,
      REFRESHING
   } bank_state_t;

endpackage

// File: rtl/sal_tcnt.sv
// Loadable down-counter that sticks at zero; zero flag marks a released constraint.
module sal_tcnt #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          zero
);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sal_bank_fsm.sv
// Per-bank DDR2 state machine: tracks bank state, enforces bank timing,
// and reports which commands the scheduler may issue this cycle.
module sal_bank_fsm
   import sal_bank_pkg::*;
#(
   parameter int ROW_AW = DEF_ROW_AW,
   parameter int TW     = DEF_TW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TW-1:0]     t_rcd_m1,
   input  logic [TW-1:0]     t_rp_m1,
   input  logic [TW-1:0]     t_ras_m1,
   input  logic [TW-1:0]     t_rfc_m1,
   input  logic [TW-1:0]     t_rtp_m1,
   input  logic [TW-1:0]     t_wtp_m1,
   input  logic              act_i,
   input  logic              rd_i,
   input  logic              wr_i,
   input  logic              pre_i,
   input  logic              ref_i,
   input  logic [ROW_AW-1:0] row_i,
   output logic              act_allowed,
   output logic              rd_allowed,
   output logic              wr_allowed,
   output logic              pre_allowed,
   output logic              ref_allowed,
   output logic              is_open,
   output logic [ROW_AW-1:0] open_row,
   output logic              err_o
);

   bank_state_t state, eff_state, next_state;
   logic        rcd_zero, ras_zero, rp_zero, rfc_zero, rtp_zero, wtp_zero;
   logic [4:0]  strobes;
   logic        single;
   logic        act_acc, rd_acc, wr_acc, pre_acc, ref_acc;
   logic        violation;
   logic        err_q;

   sal_tcnt #(.TW(TW)) u_rcd (.clk(clk), .rst_n(rst_n), .load(act_acc), .load_val(t_rcd_m1), .zero(rcd_zero));
   sal_tcnt #(.TW(TW)) u_ras (.clk(clk), .rst_n(rst_n), .load(act_acc), .load_val(t_ras_m1), .zero(ras_zero));
   sal_tcnt #(.TW(TW)) u_rp  (.clk(clk), .rst_n(rst_n), .load(pre_acc), .load_val(t_rp_m1),  .zero(rp_zero));
   sal_tcnt #(.TW(TW)) u_rfc (.clk(clk), .rst_n(rst_n), .load(ref_acc), .load_val(t_rfc_m1), .zero(rfc_zero));
   sal_tcnt #(.TW(TW)) u_rtp (.clk(clk), .rst_n(rst_n), .load(rd_acc),  .load_val(t_rtp_m1), .zero(rtp_zero));
   sal_tcnt #(.TW(TW)) u_wtp (.clk(clk), .rst_n(rst_n), .load(wr_acc),  .load_val(t_wtp_m1), .zero(wtp_zero));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         open_row <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= next_state;
         err_q <= violation;
         if (act_acc) begin
            open_row <= row_i;
         end
      end
   end

   // A transitional state whose counter has run out already behaves as its
   // successor, so a constraint of m1 is released exactly m1+1 cycles after issue.
   always_comb begin
      eff_state = state;
      case (state)
         ACTIVATING:  if (rcd_zero) eff_state = ACTIVE;
         PRECHARGING: if (rp_zero)  eff_state = IDLE;
         REFRESHING:  if (rfc_zero) eff_state = IDLE;
         default:     eff_state = state;
      endcase

      act_allowed = (eff_state == IDLE);
      ref_allowed = (eff_state == IDLE);
      rd_allowed  = (eff_state == ACTIVE);
      wr_allowed  = (eff_state == ACTIVE);
      pre_allowed = (eff_state == ACTIVE) && ras_zero && rtp_zero && wtp_zero;
      is_open     = (eff_state == ACTIVE);

      strobes = {act_i, rd_i, wr_i, pre_i, ref_i};
      single  = $onehot(strobes);
      act_acc = single && act_i && act_allowed;
      rd_acc  = single && rd_i  && rd_allowed;
      wr_acc  = single && wr_i  && wr_allowed;
      pre_acc = single && pre_i && pre_allowed;
      ref_acc = single && ref_i && ref_allowed;
      violation = (strobes != 5'b0) &&
                  !(act_acc || rd_acc || wr_acc || pre_acc || ref_acc);

      next_state = eff_state;
      if (act_acc) begin
         next_state = ACTIVATING;
      end else if (ref_acc) begin
         next_state = REFRESHING;
      end else if (pre_acc) begin
         next_state = PRECHARGING;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_sal_bank_fsm.sv
// Directed scoreboard bench for sal_bank_fsm: expectations are queued as each
// cycle is driven and checked against the DUT outputs mid-cycle.
module tb_sal_bank_fsm;

   localparam int TW = 8;
   localparam int RW = 14;

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] ACT  = 5'b10000;
   localparam logic [4:0] RD   = 5'b01000;
   localparam logic [4:0] WR   = 5'b00100;
   localparam logic [4:0] PRE  = 5'b00010;
   localparam logic [4:0] REF  = 5'b00001;

   localparam int S_ACT = 0, S_RD = 1, S_WR = 2, S_PRE = 3, S_REF = 4,
                  S_OPEN = 5, S_ROW = 6, S_ERR = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [TW-1:0] t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1;
   logic          act_i, rd_i, wr_i, pre_i, ref_i;
   logic [RW-1:0] row_i;
   logic          act_allowed, rd_allowed, wr_allowed, pre_allowed, ref_allowed;
   logic          is_open;
   logic [RW-1:0] open_row;
   logic          err_o;

   typedef struct {
      string         tag;
      int            sel;
      logic [RW-1:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   sal_bank_fsm #(.ROW_AW(RW), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
      .t_rfc_m1(t_rfc_m1), .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
      .act_i(act_i), .rd_i(rd_i), .wr_i(wr_i), .pre_i(pre_i), .ref_i(ref_i),
      .row_i(row_i),
      .act_allowed(act_allowed), .rd_allowed(rd_allowed), .wr_allowed(wr_allowed),
      .pre_allowed(pre_allowed), .ref_allowed(ref_allowed),
      .is_open(is_open), .open_row(open_row), .err_o(err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] observe(input int sel);
      case (sel)
         S_ACT:   return {{(RW-1){1'b0}}, act_allowed};
         S_RD:    return {{(RW-1){1'b0}}, rd_allowed};
         S_WR:    return {{(RW-1){1'b0}}, wr_allowed};
         S_PRE:   return {{(RW-1){1'b0}}, pre_allowed};
         S_REF:   return {{(RW-1){1'b0}}, ref_allowed};
         S_OPEN:  return {{(RW-1){1'b0}}, is_open};
         S_ROW:   return open_row;
         default: return {{(RW-1){1'b0}}, err_o};
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         S_ACT:   return "act_allowed";
         S_RD:    return "rd_allowed";
         S_WR:    return "wr_allowed";
         S_PRE:   return "pre_allowed";
         S_REF:   return "ref_allowed";
         S_OPEN:  return "is_open";
         S_ROW:   return "open_row";
         default: return "err_o";
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [RW-1:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic expFlags(input string tag, input logic a, input logic r,
                           input logic w, input logic p, input logic f);
      push(tag, S_ACT, {{(RW-1){1'b0}}, a});
      push(tag, S_RD,  {{(RW-1){1'b0}}, r});
      push(tag, S_WR,  {{(RW-1){1'b0}}, w});
      push(tag, S_PRE, {{(RW-1){1'b0}}, p});
      push(tag, S_REF, {{(RW-1){1'b0}}, f});
   endtask

   task automatic applyStimulus(input logic [4:0] s, input logic [RW-1:0] row);
      @(negedge clk);
      {act_i, rd_i, wr_i, pre_i, ref_i} = s;
      row_i = row;
   endtask

   task automatic checkOutput();
      exp_t          e;
      logic [RW-1:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.val) else begin
            failures++;
            $error("[TB] FAIL %s %s observed=%0h expected=%0h",
                   e.tag, sel_name(e.sel), obs, e.val);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {act_i, rd_i, wr_i, pre_i, ref_i} = NONE;
      row_i = '0;
      t_rcd_m1 = '0; t_rp_m1 = '0; t_ras_m1 = '0;
      t_rfc_m1 = '0; t_rtp_m1 = '0; t_wtp_m1 = '0;

      // Reset values
      #2;
      expFlags("reset", 1, 0, 0, 0, 1);
      push("reset", S_OPEN, 0);
      push("reset", S_ROW, 0);
      push("reset", S_ERR, 0);
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;

      // tRCD = 4 cycles, then close via tRAS with a zero-length precharge
      t_rcd_m1 = 3; t_ras_m1 = 9; t_rp_m1 = 0; t_rtp_m1 = 0; t_wtp_m1 = 0;
      applyStimulus(ACT, 14'h1A5);
      expFlags("t1_c0", 1, 0, 0, 0, 1);
      checkOutput();
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(NONE, '0);
         push("t1_rcd_wait", S_RD, 0);
         push("t1_rcd_wait", S_OPEN, 0);
         checkOutput();
      end
      applyStimulus(NONE, '0);
      expFlags("t1_c4", 0, 1, 1, 0, 0);
      push("t1_c4", S_OPEN, 1);
      push("t1_c4", S_ROW, 14'h1A5);
      checkOutput();
      for (int c = 5; c <= 9; c++) begin
         applyStimulus(NONE, '0);
         push("t1_ras_wait", S_PRE, 0);
         checkOutput();
      end
      applyStimulus(PRE, '0);
      push("t1_c10", S_PRE, 1);
      checkOutput();
      applyStimulus(NONE, '0);
      expFlags("t1_rp0_idle", 1, 0, 0, 0, 1);
      push("t1_rp0_idle", S_OPEN, 0);
      checkOutput();

      // tRAS governs precharge despite an early read
      t_rcd_m1 = 2; t_ras_m1 = 9; t_rtp_m1 = 2; t_rp_m1 = 4;
      applyStimulus(ACT, 14'h0003);
      checkOutput();
      for (int c = 1; c <= 2; c++) begin
         applyStimulus(NONE, '0);
         push("t2_rcd_wait", S_RD, 0);
         checkOutput();
      end
      applyStimulus(RD, '0);
      push("t2_c3", S_RD, 1);
      checkOutput();
      for (int c = 4; c <= 9; c++) begin
         applyStimulus(NONE, '0);
         push("t2_ras_wait", S_PRE, 0);
         checkOutput();
      end
      applyStimulus(PRE, '0);
      push("t2_c10", S_PRE, 1);
      checkOutput();
      for (int c = 11; c <= 14; c++) begin
         applyStimulus(NONE, '0);
         push("t2_rp_wait", S_ACT, 0);
         push("t2_rp_wait", S_OPEN, 0);
         push("t2_rp_wait", S_ROW, 14'h0003);
         checkOutput();
      end
      applyStimulus(NONE, '0);
      expFlags("t2_c15", 1, 0, 0, 0, 1);
      checkOutput();

      // tRTP governs precharge when tRAS is short
      t_rcd_m1 = 2; t_ras_m1 = 0; t_rtp_m1 = 4; t_rp_m1 = 0;
      applyStimulus(ACT, 14'h0010);
      checkOutput();
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(NONE, '0);
         checkOutput();
      end
      applyStimulus(NONE, '0);
      push("t2b_c4", S_PRE, 1);
      checkOutput();
      applyStimulus(RD, '0);
      push("t2b_c5", S_PRE, 1);
      checkOutput();
      for (int c = 6; c <= 9; c++) begin
         applyStimulus(NONE, '0);
         push("t2b_rtp_wait", S_PRE, 0);
         checkOutput();
      end
      applyStimulus(PRE, '0);
      push("t2b_c10", S_PRE, 1);
      checkOutput();
      applyStimulus(NONE, '0);
      push("t2b_idle", S_ACT, 1);
      checkOutput();

      // tWTP after a late write; timing input changed mid-count
      t_rcd_m1 = 2; t_ras_m1 = 9; t_wtp_m1 = 7; t_rp_m1 = 4; t_rtp_m1 = 0;
      applyStimulus(ACT, 14'h2AB);
      checkOutput();
      for (int c = 1; c <= 19; c++) begin
         applyStimulus(NONE, '0);
         if (c == 19) begin
            push("t3_c19", S_PRE, 1);
            push("t3_c19", S_OPEN, 1);
            push("t3_c19", S_ROW, 14'h2AB);
         end
         checkOutput();
      end
      applyStimulus(WR, '0);
      push("t3_c20", S_WR, 1);
      checkOutput();
      for (int c = 21; c <= 27; c++) begin
         applyStimulus(NONE, '0);
         if (c == 21) t_wtp_m1 = 0;
         push("t3_wtp_wait", S_PRE, 0);
         checkOutput();
      end
      applyStimulus(PRE, '0);
      push("t3_c28", S_PRE, 1);
      checkOutput();
      for (int c = 29; c <= 32; c++) begin
         applyStimulus(NONE, '0);
         push("t3_rp_wait", S_ACT, 0);
         checkOutput();
      end
      applyStimulus(NONE, '0);
      expFlags("t3_c33", 1, 0, 0, 0, 1);
      checkOutput();

      // Refresh lockout
      t_rfc_m1 = 25;
      applyStimulus(REF, '0);
      push("t4_c0", S_REF, 1);
      checkOutput();
      for (int c = 1; c <= 25; c++) begin
         applyStimulus(NONE, '0);
         if (c == 5) t_rfc_m1 = 3;
         push("t4_rfc_wait", S_REF, 0);
         push("t4_rfc_wait", S_ACT, 0);
         checkOutput();
      end
      applyStimulus(NONE, '0);
      expFlags("t4_c26", 1, 0, 0, 0, 1);
      checkOutput();

      // Protocol violations: two strobes, then a disallowed strobe
      t_rfc_m1 = 25;
      applyStimulus(ACT | REF, 14'h0777);
      push("t5_dual_c0", S_ERR, 0);
      checkOutput();
      applyStimulus(NONE, '0);
      push("t5_dual_c1", S_ERR, 1);
      expFlags("t5_dual_c1", 1, 0, 0, 0, 1);
      push("t5_dual_c1", S_OPEN, 0);
      checkOutput();
      applyStimulus(NONE, '0);
      push("t5_dual_c2", S_ERR, 0);
      checkOutput();
      applyStimulus(RD, '0);
      push("t5_rd_c0", S_RD, 0);
      checkOutput();
      applyStimulus(NONE, '0);
      push("t5_rd_c1", S_ERR, 1);
      push("t5_rd_c1", S_ACT, 1);
      checkOutput();
      applyStimulus(NONE, '0);
      push("t5_rd_c2", S_ERR, 0);
      push("t5_rd_c2", S_ROW, 14'h2AB);
      checkOutput();

      // Asynchronous reset in the middle of a refresh, with an error pending
      applyStimulus(REF, '0);
      checkOutput();
      for (int c = 1; c <= 8; c++) begin
         applyStimulus(NONE, '0);
         checkOutput();
      end
      applyStimulus(RD, '0);
      checkOutput();
      applyStimulus(NONE, '0);
      push("t6_c10_pre", S_ERR, 1);
      push("t6_c10_pre", S_ACT, 0);
      checkOutput();
      rst_n = 1'b0;
      expFlags("t6_rst", 1, 0, 0, 0, 1);
      push("t6_rst", S_ERR, 0);
      push("t6_rst", S_OPEN, 0);
      push("t6_rst", S_ROW, 0);
      checkOutput();
      #1;
      rst_n = 1'b1;
      applyStimulus(NONE, '0);
      expFlags("t6_after", 1, 0, 0, 0, 1);
      checkOutput();

      // Maximum count: 2^TW cycles of refresh
      t_rfc_m1 = 8'hFF;
      applyStimulus(REF, '0);
      checkOutput();
      for (int c = 1; c <= 255; c++) begin
         applyStimulus(NONE, '0);
         if (c == 1 || c == 255) begin
            push("t7_max_wait", S_REF, 0);
         end
         checkOutput();
      end
      applyStimulus(NONE, '0);
      push("t7_c256", S_REF, 1);
      push("t7_c256", S_ACT, 1);
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
